// File: rtl/nibble_program_loader_if.sv
// Stream and CPU-side signals of the nibble program loader.
// The slave is the loader itself; the master is whoever streams programs in and fetches instructions.
interface nibble_program_loader_if;
  logic       start;
  logic [3:0] in_nibble;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] program_counter;
  logic [7:0] instruction;
  logic       cpu_reset;
  logic       loading;
  logic       done;
  logic       error;

  modport master (
    output start, in_nibble, in_valid, program_counter,
    input  in_ready, instruction, cpu_reset, loading, done, error
  );

  modport slave (
    input  start, in_nibble, in_valid, program_counter,
    output in_ready, instruction, cpu_reset, loading, done, error
  );
endinterface

// File: rtl/nibble_program_loader.sv
// Loads a 32x8 instruction RAM from a length-prefixed nibble stream, zero-fills the tail,
// and holds the CPU in reset until the image is complete.
module nibble_program_loader #(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  nibble_program_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_INS_HI, S_INS_LO, S_FILL, S_RUN, S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_len;
  logic [ADDR_W-1:0]   w_len_next;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADDR_W-1:0]   w_wr_addr_next;
  logic [3:0]          r_hi;
  logic [3:0]          w_hi_next;
  logic                r_in_ready;
  logic                r_cpu_reset;
  logic                r_loading;
  logic                r_done;
  logic                r_error;
  logic                w_xfer;
  logic                w_wr_en;
  logic [INSTR_W-1:0]  w_wr_data;
  logic [INSTR_W-1:0]  r_mem [DEPTH];

  assign w_xfer = bus.in_valid & r_in_ready;

  always_comb begin
    w_state_next   = r_state;
    w_len_next     = r_len;
    w_wr_addr_next = r_wr_addr;
    w_hi_next      = r_hi;
    w_wr_en        = 1'b0;
    w_wr_data      = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_xfer) begin
          // Only 32 words exist, so the length high nibble may only be 0 or 1.
          if (bus.in_nibble > 4'd1) begin
            w_state_next = S_ERR;
          end else begin
            w_len_next[4] = bus.in_nibble[0];
            w_state_next  = S_LEN_LO;
          end
        end
      end
      S_LEN_LO: begin
        if (w_xfer) begin
          w_len_next[3:0] = bus.in_nibble;
          w_wr_addr_next  = '0;
          w_state_next    = S_INS_HI;
        end
      end
      S_INS_HI: begin
        if (w_xfer) begin
          w_hi_next    = bus.in_nibble;
          w_state_next = S_INS_LO;
        end
      end
      S_INS_LO: begin
        if (w_xfer) begin
          w_wr_en   = 1'b1;
          w_wr_data = {r_hi, bus.in_nibble};
          if (r_wr_addr == r_len) begin
            if (r_len == LAST_ADDR) begin
              w_state_next = S_RUN;
            end else begin
              w_state_next   = S_FILL;
              w_wr_addr_next = r_wr_addr + ADDR_W'(1);
            end
          end else begin
            w_wr_addr_next = r_wr_addr + ADDR_W'(1);
            w_state_next   = S_INS_HI;
          end
        end
      end
      S_FILL: begin
        w_wr_en   = 1'b1;
        w_wr_data = '0;
        if (r_wr_addr == LAST_ADDR) w_state_next   = S_RUN;
        else                        w_wr_addr_next = r_wr_addr + ADDR_W'(1);
      end
      S_RUN: begin
        if (bus.start) w_state_next = S_LEN_HI;
      end
      S_ERR: begin
        if (bus.start) w_state_next = S_LEN_HI;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_wr_addr   <= '0;
      r_hi        <= '0;
      r_in_ready  <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_loading   <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_len       <= w_len_next;
      r_wr_addr   <= w_wr_addr_next;
      r_hi        <= w_hi_next;
      r_in_ready  <= (w_state_next == S_LEN_HI) || (w_state_next == S_LEN_LO) ||
                     (w_state_next == S_INS_HI) || (w_state_next == S_INS_LO);
      r_cpu_reset <= (w_state_next != S_RUN);
      r_loading   <= (w_state_next == S_LEN_HI) || (w_state_next == S_LEN_LO) ||
                     (w_state_next == S_INS_HI) || (w_state_next == S_INS_LO) ||
                     (w_state_next == S_FILL);
      r_done      <= (w_state_next == S_RUN);
      r_error     <= (w_state_next == S_ERR);
    end
  end

  // RAM contents survive reset; only a write in progress is suppressed.
  always_ff @(posedge clk) begin
    if (w_wr_en && !reset) r_mem[r_wr_addr] <= w_wr_data;
  end

  assign bus.instruction = r_mem[bus.program_counter];
  assign bus.in_ready    = r_in_ready;
  assign bus.cpu_reset   = r_cpu_reset;
  assign bus.loading     = r_loading;
  assign bus.done        = r_done;
  assign bus.error       = r_error;

endmodule

// File: tb/tb_nibble_program_loader.sv
// Directed bench for the nibble program loader: loads, zero-fill, length errors, gaps and reset mid-load.
module tb_nibble_program_loader;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  nibble_program_loader_if bus();

  nibble_program_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] n);
    int w;
    w = 0;
    bus.in_nibble = n;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && w < 50) begin
      tick();
      w++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles, required 1", w);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send(b[7:4]);
    send(b[3:0]);
  endtask

  // One transfer followed by one idle cycle carrying junk data.
  task automatic send_gap(input logic [3:0] n);
    send(n);
    bus.in_nibble = 4'hF;
    tick();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    reset        = 1'b1;
    tick();
    reset        = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.done && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic check_mem(input string tag, input logic [4:0] a, input logic [7:0] exp);
    bus.program_counter = a;
    #1;
    check(tag, bus.instruction, exp);
  endtask

  int cyc;
  logic [4:0] ii;

  initial begin
    reset               = 1'b1;
    bus.start           = 1'b0;
    bus.in_valid        = 1'b0;
    bus.in_nibble       = 4'h0;
    bus.program_counter = 5'd0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_cpu_reset", bus.cpu_reset, 1);
    check("rst_in_ready",  bus.in_ready, 0);
    check("rst_loading",   bus.loading, 0);
    check("rst_done",      bus.done, 0);
    check("rst_error",     bus.error, 0);

    // Full 32-word load: no FILL phase, RUN right after the last transfer
    pulse_start();
    check("full_in_ready", bus.in_ready, 1);
    check("full_loading",  bus.loading, 1);
    send(4'h1);
    send(4'hF);
    for (int i = 0; i < 32; i++) begin
      ii = 5'(i);
      send_byte({~ii[3:0], ii[3:0]});
    end
    check("full_done_now",  bus.done, 1);
    check("full_cpu_reset", bus.cpu_reset, 0);
    check("full_loading_0", bus.loading, 0);
    check("full_in_ready0", bus.in_ready, 0);
    check_mem("full_m0",  5'd0,  8'hF0);
    check_mem("full_m7",  5'd7,  8'h87);
    check_mem("full_m16", 5'd16, 8'hF0);
    check_mem("full_m20", 5'd20, 8'hB4);
    check_mem("full_m31", 5'd31, 8'h0F);
    tick();

    // Single word A5 then 31 cycles of zero-fill; in_valid in IDLE is ignored
    do_reset();
    check("r1_cpu_reset", bus.cpu_reset, 1);
    check("r1_done",      bus.done, 0);
    bus.in_nibble = 4'h1;
    bus.in_valid  = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    check("idle_valid_loading",  bus.loading, 0);
    check("idle_valid_in_ready", bus.in_ready, 0);
    pulse_start();
    send(4'h0);
    send(4'h0);
    send(4'hA);
    send(4'h5);
    check("one_fill_loading", bus.loading, 1);
    check("one_fill_ready",   bus.in_ready, 0);
    check("one_fill_done",    bus.done, 0);
    wait_done(cyc);
    check("one_fill_cycles", cyc, 31);
    check("one_cpu_reset",   bus.cpu_reset, 0);
    check("one_done",        bus.done, 1);
    check_mem("one_m0", 5'd0, 8'hA5);
    for (int a = 1; a < 32; a++) check_mem($sformatf("one_fill_m%0d", a), 5'(a), 8'h00);
    tick();

    // Three words with in_valid toggling every cycle
    pulse_start();
    send_gap(4'h0);
    send_gap(4'h2);
    send_gap(4'h1); send_gap(4'h1);
    send_gap(4'hC); send_gap(4'h2);
    send_gap(4'h3); send(4'hE);
    wait_done(cyc);
    check("gap_fill_cycles", cyc, 29);
    check_mem("gap_m0", 5'd0, 8'h11);
    check_mem("gap_m1", 5'd1, 8'hC2);
    check_mem("gap_m2", 5'd2, 8'h3E);
    check_mem("gap_m3", 5'd3, 8'h00);
    tick();

    // start in RUN: CPU goes back into reset, new 1-word program 3C
    pulse_start();
    check("rerun_cpu_reset", bus.cpu_reset, 1);
    check("rerun_done",      bus.done, 0);
    send_byte(8'h00);
    send_byte(8'h3C);
    wait_done(cyc);
    check("rerun_fill_cycles", cyc, 31);
    check("rerun_cpu_reset0",  bus.cpu_reset, 0);
    check_mem("rerun_m0", 5'd0, 8'h3C);
    check_mem("rerun_m1", 5'd1, 8'h00);
    check_mem("rerun_m2", 5'd2, 8'h00);
    tick();

    // Bad length high nibble, then recovery with a 2-word program
    pulse_start();
    send(4'h2);
    check("err_error",     bus.error, 1);
    check("err_in_ready",  bus.in_ready, 0);
    check("err_cpu_reset", bus.cpu_reset, 1);
    check("err_loading",   bus.loading, 0);
    tick();
    check("err_hold",      bus.error, 1);
    pulse_start();
    check("err_cleared",   bus.error, 0);
    check("err_restart_rdy", bus.in_ready, 1);
    send(4'h0);
    send(4'h1);
    send_byte(8'h44);
    send_byte(8'h55);
    wait_done(cyc);
    check("err_fill_cycles", cyc, 30);
    check_mem("err_m0", 5'd0, 8'h44);
    check_mem("err_m1", 5'd1, 8'h55);
    check_mem("err_m2", 5'd2, 8'h00);
    tick();

    // Reset after 2 of 4 words (start during load ignored), then reload
    pulse_start();
    send_byte(8'h03);
    send_byte(8'hDE);
    bus.start = 1'b1;
    send_byte(8'hAD);
    bus.start = 1'b0;
    check("mid_loading", bus.loading, 1);
    do_reset();
    check("mid_cpu_reset", bus.cpu_reset, 1);
    check("mid_done",      bus.done, 0);
    check("mid_loading0",  bus.loading, 0);
    check("mid_in_ready",  bus.in_ready, 0);
    check_mem("mid_m0", 5'd0, 8'hDE);
    check_mem("mid_m1", 5'd1, 8'hAD);
    check_mem("mid_m2", 5'd2, 8'h00);
    tick();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h77);
    wait_done(cyc);
    check("reload_fill_cycles", cyc, 31);
    check("reload_done",        bus.done, 1);
    check_mem("reload_m0", 5'd0, 8'h77);
    check_mem("reload_m1", 5'd1, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
